// File: rtl/float64_to_float32.sv
// Three-stage AXI-Stream narrowing converter, binary64 -> binary32, round-to-nearest-even.
// Flags on tuser are {overflow, underflow, inexact}; SUBNORMAL_EN=0 flushes tiny results to signed zero.
module float64_to_float32 #(
  parameter bit SUBNORMAL_EN = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  output logic [31:0] m_axis_result_tdata,
  output logic [2:0]  m_axis_result_tuser,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready
);

  logic advance;

  logic        s1_valid, s1_sign, s1_exp_max, s1_exp_zero, s1_man_zero;
  logic [10:0] s1_exp;
  logic [51:0] s1_man;

  logic        s2_valid, s2_sign, s2_spec, s2_guard, s2_sticky, s2_tiny;
  logic [30:0] s2_spec_mag;
  logic [2:0]  s2_spec_flags;
  logic [7:0]  s2_exp;
  logic [22:0] s2_kept;

  logic        n2_spec, n2_guard, n2_sticky, n2_tiny;
  logic [30:0] n2_spec_mag;
  logic [2:0]  n2_spec_flags;
  logic [7:0]  n2_exp;
  logic [22:0] n2_kept;
  logic [10:0] tiny_shift;
  logic [4:0]  shift_m1;
  logic [77:0] wide;

  logic        round_up, inexact, overflow, underflow;
  logic [30:0] rounded;

  assign advance         = m_axis_result_tready | ~m_axis_result_tvalid;
  assign s_axis_a_tready = advance;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_man      <= '0;
      s1_exp_max  <= 1'b0;
      s1_exp_zero <= 1'b0;
      s1_man_zero <= 1'b0;
    end else if (advance) begin
      s1_valid    <= s_axis_a_tvalid;
      s1_sign     <= s_axis_a_tdata[63];
      s1_exp      <= s_axis_a_tdata[62:52];
      s1_man      <= s_axis_a_tdata[51:0];
      s1_exp_max  <= &s_axis_a_tdata[62:52];
      s1_exp_zero <= ~|s_axis_a_tdata[62:52];
      s1_man_zero <= ~|s_axis_a_tdata[51:0];
    end
  end

  // Tiny inputs are denormalised by (897 - e); the leading 1 lands at kept[22] for a shift of 1,
  // so the shifter runs with (shift - 1), capped where every bit has already fallen into sticky.
  always_comb begin
    tiny_shift    = 11'd897 - s1_exp;
    shift_m1      = (tiny_shift > 11'd26) ? 5'd25 : (tiny_shift[4:0] - 5'd1);
    wide          = {1'b1, s1_man, 25'b0} >> shift_m1;
    n2_spec       = 1'b0;
    n2_spec_mag   = '0;
    n2_spec_flags = 3'b000;
    n2_exp        = s1_exp[7:0] - 8'h80;
    n2_kept       = s1_man[51:29];
    n2_guard      = s1_man[28];
    n2_sticky     = |s1_man[27:0];
    n2_tiny       = 1'b0;
    if (s1_exp_max) begin
      n2_spec     = 1'b1;
      n2_spec_mag = s1_man_zero ? 31'h7F80_0000 : 31'h7FC0_0000;
    end else if (s1_exp_zero) begin
      n2_spec       = 1'b1;
      n2_spec_flags = s1_man_zero ? 3'b000 : 3'b011;
    end else if (s1_exp > 11'd1150) begin
      n2_spec       = 1'b1;
      n2_spec_mag   = 31'h7F80_0000;
      n2_spec_flags = 3'b101;
    end else if (s1_exp < 11'd897) begin
      if (!SUBNORMAL_EN) begin
        n2_spec       = 1'b1;
        n2_spec_flags = 3'b011;
      end else begin
        n2_exp    = 8'd0;
        n2_kept   = wide[77:55];
        n2_guard  = wide[54];
        n2_sticky = |wide[53:0];
        n2_tiny   = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s2_valid      <= 1'b0;
      s2_sign       <= 1'b0;
      s2_spec       <= 1'b0;
      s2_spec_mag   <= '0;
      s2_spec_flags <= '0;
      s2_exp        <= '0;
      s2_kept       <= '0;
      s2_guard      <= 1'b0;
      s2_sticky     <= 1'b0;
      s2_tiny       <= 1'b0;
    end else if (advance) begin
      s2_valid      <= s1_valid;
      s2_sign       <= s1_sign;
      s2_spec       <= n2_spec;
      s2_spec_mag   <= n2_spec_mag;
      s2_spec_flags <= n2_spec_flags;
      s2_exp        <= n2_exp;
      s2_kept       <= n2_kept;
      s2_guard      <= n2_guard;
      s2_sticky     <= n2_sticky;
      s2_tiny       <= n2_tiny;
    end
  end

  // Mantissa carry ripples straight into the exponent field, which covers both
  // subnormal-to-min-normal and max-normal-to-infinity.
  always_comb begin
    round_up  = s2_guard & (s2_sticky | s2_kept[0]);
    rounded   = {s2_exp, s2_kept} + {30'd0, round_up};
    inexact   = s2_guard | s2_sticky;
    overflow  = &rounded[30:23];
    underflow = s2_tiny & inexact;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_tuser  <= '0;
    end else if (advance) begin
      m_axis_result_tvalid <= s2_valid;
      if (s2_valid) begin
        m_axis_result_tdata <= {s2_sign, s2_spec ? s2_spec_mag : rounded};
        m_axis_result_tuser <= s2_spec ? s2_spec_flags : {overflow, underflow, inexact};
      end
    end
  end

endmodule

// File: tb/tb_float64_to_float32.sv
// Directed-vector bench for float64_to_float32: conversion table, latency, stall hold and mid-stream reset.
module tb_float64_to_float32;

  localparam int NVEC = 20;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready, s_tready_f;
  logic [31:0] m_tdata, m_tdata_f;
  logic [2:0]  m_tuser, m_tuser_f;
  logic        m_tvalid, m_tvalid_f;
  logic        m_tready = 1'b1;

  int checks = 0;
  int fails  = 0;

  logic [63:0] vin [NVEC] = '{
    64'h3FF0000000000000, 64'hC000000000000000, 64'h3FF0000010000000, 64'h3FF0000030000000,
    64'h3FF0000010000001, 64'h47EFFFFFE0000000, 64'h47EFFFFFF0000000, 64'h47F0000000000000,
    64'h36A0000000000000, 64'h3690000000000000, 64'h3810000000000000, 64'hFFF0000000000000,
    64'h7FF8000000000001, 64'h8000000000000000, 64'h0000000000000001, 64'h380FFFFFF0000000,
    64'hBFF8000000000000, 64'h8000000000000001, 64'h36A8000000000000, 64'hC7F0000000000000};
  logic [31:0] vout [NVEC] = '{
    32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3F800002,
    32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000,
    32'h00000001, 32'h00000000, 32'h00800000, 32'hFF800000,
    32'h7FC00000, 32'h80000000, 32'h00000000, 32'h00800000,
    32'hBFC00000, 32'h80000000, 32'h00000002, 32'hFF800000};
  logic [2:0] vflg [NVEC] = '{
    3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b101, 3'b101, 3'b000, 3'b011,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b000, 3'b011, 3'b011, 3'b101};
  // Expected results for the flush-to-zero variant; only the tiny inputs differ
  logic [31:0] fout [NVEC] = '{
    32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3F800002,
    32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000,
    32'h00000000, 32'h00000000, 32'h00800000, 32'hFF800000,
    32'h7FC00000, 32'h80000000, 32'h00000000, 32'h00000000,
    32'hBFC00000, 32'h80000000, 32'h00000000, 32'hFF800000};
  logic [2:0] fflg [NVEC] = '{
    3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b101, 3'b101, 3'b011, 3'b011,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b000, 3'b011, 3'b011, 3'b101};

  float64_to_float32 #(.SUBNORMAL_EN(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(s_tdata), .s_axis_a_tvalid(s_tvalid), .s_axis_a_tready(s_tready),
    .m_axis_result_tdata(m_tdata), .m_axis_result_tuser(m_tuser),
    .m_axis_result_tvalid(m_tvalid), .m_axis_result_tready(m_tready));

  float64_to_float32 #(.SUBNORMAL_EN(1'b0)) dut_flush (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(s_tdata), .s_axis_a_tvalid(s_tvalid), .s_axis_a_tready(s_tready_f),
    .m_axis_result_tdata(m_tdata_f), .m_axis_result_tuser(m_tuser_f),
    .m_axis_result_tvalid(m_tvalid_f), .m_axis_result_tready(m_tready));

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One operand through an otherwise empty pipeline; latency counts edges including the accepting one
  task automatic applyStimulus(input int idx);
    int cycles;
    s_tdata  = vin[idx];
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    cycles = 1;
    while (!m_tvalid && cycles < 8) begin
      @(posedge aclk);
      #1;
      cycles++;
    end
    checkOutput($sformatf("v%0d latency", idx), 64'(cycles), 64'd3);
    checkOutput($sformatf("v%0d data", idx), 64'(m_tdata), 64'(vout[idx]));
    checkOutput($sformatf("v%0d flags", idx), 64'(m_tuser), 64'(vflg[idx]));
    checkOutput($sformatf("v%0d flush valid", idx), 64'(m_tvalid_f), 64'd1);
    checkOutput($sformatf("v%0d flush data", idx), 64'(m_tdata_f), 64'(fout[idx]));
    checkOutput($sformatf("v%0d flush flags", idx), 64'(m_tuser_f), 64'(fflg[idx]));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int sent, got, stale;
    logic acc, have_prev;
    logic [63:0] prev;

    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    checkOutput("reset tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset tdata", 64'(m_tdata), 64'd0);
    checkOutput("reset tuser", 64'(m_tuser), 64'd0);
    checkOutput("reset s_tready", 64'(s_tready), 64'd1);

    for (int i = 0; i < NVEC; i++) applyStimulus(i);

    // Back-to-back stream with a five-cycle downstream stall in the middle
    sent = 0;
    got = 0;
    have_prev = 1'b0;
    prev = '0;
    fork
      begin
        int guard = 0;
        while (sent < 10 && guard < 100) begin
          s_tdata  = vin[sent];
          s_tvalid = 1'b1;
          @(negedge aclk);
          acc = s_tready;
          @(posedge aclk);
          #1;
          if (acc) sent++;
          guard++;
        end
        s_tvalid = 1'b0;
      end
      begin
        repeat (5) @(posedge aclk);
        #1;
        m_tready = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
      begin
        repeat (40) begin
          @(negedge aclk);
          if (m_tvalid && !m_tready) begin
            checkOutput("stall s_tready", 64'(s_tready), 64'd0);
            checkOutput("stall flush s_tready", 64'(s_tready_f), 64'd0);
            if (have_prev) checkOutput("stall hold", {28'd0, m_tdata, m_tuser, m_tvalid}, prev);
            prev = {28'd0, m_tdata, m_tuser, m_tvalid};
            have_prev = 1'b1;
          end else begin
            have_prev = 1'b0;
          end
          if (m_tvalid && m_tready) begin
            if (got < 10) begin
              checkOutput($sformatf("stream %0d data", got), 64'(m_tdata), 64'(vout[got]));
              checkOutput($sformatf("stream %0d flags", got), 64'(m_tuser), 64'(vflg[got]));
            end
            got++;
          end
        end
      end
    join
    checkOutput("stream sent", 64'(sent), 64'd10);
    checkOutput("stream received", 64'(got), 64'd10);

    // Fill the pipeline, then pulse reset: nothing in flight may surface afterwards
    for (int i = 0; i < 3; i++) begin
      s_tdata  = vin[i + 5];
      s_tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    checkOutput("midreset tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("midreset tdata", 64'(m_tdata), 64'd0);
    checkOutput("midreset tuser", 64'(m_tuser), 64'd0);
    stale = 0;
    repeat (6) begin
      @(posedge aclk);
      #1;
      if (m_tvalid) stale++;
    end
    checkOutput("midreset stale outputs", 64'(stale), 64'd0);
    applyStimulus(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/float64_to_float32.md
Name: float64_to_float32

Overview:
- Pipelined AXI-Stream narrowing converter from IEEE-754 binary64 to binary32, with round-to-nearest-even and exception flags.
- Sits directly downstream of the float64 sqrt stage: its m_axis_result feeds this block's s_axis_a.
- Its output feeds the float32 datapath and the float32 result buffers.

Parameters:
- SUBNORMAL_EN, 1: 1 = produce binary32 subnormals; 0 = flush tiny results to signed zero.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_axis_a_tdata  in  64  binary64 operand
- s_axis_a_tvalid  in  1  operand valid
- s_axis_a_tready  out  1  block can accept
- m_axis_result_tdata  out  32  binary32 result
- m_axis_result_tuser  out  3  flags {overflow, underflow, inexact}
- m_axis_result_tvalid  out  1  result valid
- m_axis_result_tready  in  1  downstream accepts

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk. While aresetn=0 at a clock edge, all stage valids clear, so m_axis_result_tvalid=0 on the following cycle. m_axis_result_tdata and m_axis_result_tuser reset to 0. Reset mid-stream discards all in-flight items with no partial outputs.
- Pipeline: 3 register stages.
  - S1 unpack/classify: sign, exponent e (11b), mantissa m (52b); class zero/denorm/normal/inf/nan.
  - S2 rebias/align: compute the 23b kept mantissa, guard bit, sticky bit, biased exponent, and a pre-round overflow/tiny decision.
  - S3 round/pack: RNE increment, carry into exponent, pack the result and flags.
- Latency: result is valid 3 cycles after the accepting edge when unstalled. Throughput is 1/cycle.
- Handshake:
  - advance = m_axis_result_tready | !m_axis_result_tvalid.
  - s_axis_a_tready = advance (combinational).
  - All stages shift together only when advance=1; bubbles propagate as valid=0.
  - When stalled (tvalid=1, tready=0), output tdata, tuser and tvalid hold stable.
  - An input is accepted only on tvalid & tready.
- Arithmetic: E = e - 1023.
  - e=2047, m≠0: output sign | 0x7FC00000 (canonical quiet NaN, payload dropped). Flags 000.
  - e=2047, m=0: output sign | 0x7F800000. Flags 000.
  - e=0, m=0: output signed zero. Flags 000.
  - e=0, m≠0 (binary64 subnormal): output signed zero. Flags 011.
  - E>127: output signed inf. Flags 101.
  - -126≤E≤127, normal path:
    - kept = m[51:29], guard = m[28], sticky = |m[27:0].
    - Round up iff guard & (sticky | kept[0]).
    - A mantissa carry increments the exponent. If the exponent reaches 255, output inf with flags 101.
    - inexact = guard | sticky.
  - E<-126, tiny path:
    - Significand {1,m} is shifted right by (-126-E). Bits shifted out feed guard/sticky; RNE as above.
    - A shift >25 yields all-sticky, giving zero plus inexact.
    - Rounding up to 0x00800000 is allowed (min normal).
    - underflow = tiny & inexact, where tiny is decided before rounding.
    - SUBNORMAL_EN=0: output signed zero, flags 011, regardless of exactness.
- Sign is always preserved, including on zero, inf and NaN.
- No internal FSM beyond stage valids. No state survives reset.

Test Plan:
- Basic conversion: 0x3FF0000000000000 (1.0), tready=1 → 0x3F800000, flags 000, valid exactly 3 cycles after acceptance. Also 0xC000000000000000 → 0xC0000000.
- Rounding:
  - 0x3FF0000010000000 (tie, lsb 0) → 0x3F800000, flags 001.
  - 0x3FF0000030000000 (tie, lsb 1) → 0x3F800002, flags 001.
  - 0x3FF0000010000001 → 0x3F800001, flags 001.
- Overflow:
  - 0x47EFFFFFE0000000 → 0x7F7FFFFF, flags 000.
  - 0x47EFFFFFF0000000 → 0x7F800000, flags 101.
  - 0x47F0000000000000 → 0x7F800000, flags 101.
- Tiny:
  - 0x36A0000000000000 (2^-149) → 0x00000001, flags 000.
  - 0x3690000000000000 (2^-150, tie) → 0x00000000, flags 011.
  - 0x3810000000000000 → 0x00800000, flags 000.
  - With SUBNORMAL_EN=0: 0x36A0000000000000 → 0x00000000, flags 011.
- Specials:
  - 0xFFF0000000000000 → 0xFF800000.
  - 0x7FF8000000000001 → 0x7FC00000.
  - 0x8000000000000000 → 0x80000000.
  - 0x0000000000000001 → 0x00000000, flags 011.
- Flow control: stream 10 back-to-back operands, drop m_axis_result_tready for 5 cycles mid-stream → tdata/tuser/tvalid stable while stalled, s_axis_a_tready low, all 10 results delivered in order with no loss or duplication. Assert aresetn=0 for one cycle mid-stream → tvalid=0 the next cycle and no stale outputs afterwards.
